// File: rtl/scramble_sequencer.sv
// Scramble sequencer for the 4x4 cell array: issues NUM_MOVES pseudo-random legal
// moves (row/col select, add_n, fire) after each start, driven by a free-running LFSR.
module scramble_sequencer #(
    parameter int unsigned NUM_MOVES  = 8,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] row_out,
    output logic [3:0] col_out,
    output logic       add_n_out,
    output logic       fire_out,
    output logic [7:0] moves_issued
);

    typedef enum logic [2:0] {IDLE, SETUP, FIRE, GAP, DONE} state_t;

    localparam logic [7:0]  MOVES_LIM = 8'(NUM_MOVES);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] gap_cnt;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Selection registers are loaded on the edge that enters SETUP, so the
    // select lines are already stable for the whole SETUP cycle before fire rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            gap_cnt      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            row_out      <= '0;
            col_out      <= '0;
            add_n_out    <= 1'b0;
            fire_out     <= 1'b0;
            moves_issued <= '0;
        end else begin
            lfsr     <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
            done     <= 1'b0;
            fire_out <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                row_out   <= '0;
                col_out   <= '0;
                add_n_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            moves_issued <= '0;
                            if (MOVES_LIM == 8'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= SETUP;
                                busy      <= 1'b1;
                                row_out   <= lfsr[0] ? 4'b0000 : onehot(lfsr[2:1]);
                                col_out   <= lfsr[0] ? onehot(lfsr[2:1]) : 4'b0000;
                                add_n_out <= lfsr[3];
                            end
                        end
                    end
                    SETUP: begin
                        state    <= FIRE;
                        fire_out <= 1'b1;
                        if (moves_issued != 8'hFF)
                            moves_issued <= moves_issued + 8'd1;
                    end
                    FIRE: begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            if (moves_issued == MOVES_LIM) begin
                                state     <= DONE;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                row_out   <= '0;
                                col_out   <= '0;
                                add_n_out <= 1'b0;
                            end else begin
                                state     <= SETUP;
                                row_out   <= lfsr[0] ? 4'b0000 : onehot(lfsr[2:1]);
                                col_out   <= lfsr[0] ? onehot(lfsr[2:1]) : 4'b0000;
                                add_n_out <= lfsr[3];
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer: move timing, LFSR-driven selection, abort,
// start-while-busy, NUM_MOVES=0 and asynchronous reset.
module tb_scramble_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       busy, done, add_n_out, fire_out;
    logic [3:0] row_out, col_out;
    logic [7:0] moves_issued;

    logic       start0 = 1'b0, abort0 = 1'b0;
    logic       busy0, done0, add_n0, fire0;
    logic [3:0] row0, col0;
    logic [7:0] moves0;

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0;
    int done_cnt = 0, bad0 = 0;
    logic [15:0] m_lfsr, lf;

    scramble_sequencer #(.NUM_MOVES(8), .GAP_CYCLES(4), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .row_out(row_out), .col_out(col_out),
        .add_n_out(add_n_out), .fire_out(fire_out), .moves_issued(moves_issued)
    );

    scramble_sequencer #(.NUM_MOVES(0), .GAP_CYCLES(4), .LFSR_SEED(16'hACE1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .busy(busy0), .done(done0), .row_out(row0), .col_out(col0),
        .add_n_out(add_n0), .fire_out(fire0), .moves_issued(moves0)
    );

    always #5 clk = ~clk;

    // Reference LFSR: Galois, right shift, mask B400, reset to ACE1
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (busy0 || fire0) bad0++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_row(input logic [15:0] v);
        return v[0] ? 4'b0000 : (4'b0001 << v[2:1]);
    endfunction

    function automatic logic [3:0] exp_col(input logic [15:0] v);
        return v[0] ? (4'b0001 << v[2:1]) : 4'b0000;
    endfunction

    // Entered in the SETUP cycle of move m; leaves the bench in GAP cycle 'gaps'
    task automatic run_move(input int m, input int gaps);
        chk("setup_busy", busy, 1);
        chk("setup_fire", fire_out, 0);
        chk("setup_row", row_out, exp_row(lf));
        chk("setup_col", col_out, exp_col(lf));
        chk("setup_addn", add_n_out, lf[3]);
        tick;
        chk("fire_strobe", fire_out, 1);
        chk("fire_time", 16'(cyc - start_cyc), 16'(2 + 6 * m));
        chk("fire_count", moves_issued, 16'(m + 1));
        chk("fire_row", row_out, exp_row(lf));
        chk("fire_col", col_out, exp_col(lf));
        for (int g = 1; g <= gaps; g++) begin
            tick;
            chk("gap_fire", fire_out, 0);
            chk("gap_row", row_out, exp_row(lf));
            chk("gap_col", col_out, exp_col(lf));
            chk("gap_addn", add_n_out, lf[3]);
        end
    endtask

    initial begin
        // Reset state
        tick; tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_row", row_out, 0);
        chk("rst_col", col_out, 0);
        chk("rst_fire", fire_out, 0);
        chk("rst_moves", moves_issued, 0);
        reset = 1'b1;
        tick; tick; tick;

        // Full scramble: 8 moves, 6 cycles apart, done at start+49
        lf = m_lfsr; start = 1'b1; start_cyc = cyc; tick; start = 1'b0;
        for (int m = 0; m < 8; m++) begin
            run_move(m, 4);
            lf = m_lfsr;
            tick;
        end
        chk("done_pulse", done, 1);
        chk("done_time", 16'(cyc - start_cyc), 16'd49);
        chk("done_busy", busy, 0);
        chk("done_moves", moves_issued, 8);
        chk("done_row", row_out, 0);
        chk("done_col", col_out, 0);
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        tick;
        chk("abort_idle_busy2", busy, 0);
        chk("abort_idle_moves", moves_issued, 8);

        // Abort on 3rd GAP cycle of move 4
        done_cnt = 0;
        lf = m_lfsr; start = 1'b1; start_cyc = cyc; tick; start = 1'b0;
        for (int m = 0; m < 3; m++) begin
            run_move(m, 4);
            lf = m_lfsr;
            tick;
        end
        run_move(3, 3);
        abort = 1'b1; tick; abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_row", row_out, 0);
        chk("abort_col", col_out, 0);
        chk("abort_addn", add_n_out, 0);
        chk("abort_fire", fire_out, 0);
        chk("abort_moves", moves_issued, 4);
        tick; tick; tick;
        chk("abort_no_done", 16'(done_cnt), 0);
        chk("abort_still_idle", busy, 0);

        // start held high throughout: one done, then a fresh scramble from IDLE
        done_cnt = 0;
        lf = m_lfsr; start = 1'b1; start_cyc = cyc; tick;
        for (int m = 0; m < 8; m++) begin
            run_move(m, 4);
            lf = m_lfsr;
            tick;
        end
        chk("rep_done", done, 1);
        chk("rep_moves", moves_issued, 8);
        tick;
        chk("rep_done_cnt", 16'(done_cnt), 1);
        chk("rep_idle_busy", busy, 0);
        lf = m_lfsr; tick; start = 1'b0;
        chk("fresh_busy", busy, 1);
        chk("fresh_moves", moves_issued, 0);
        chk("fresh_row", row_out, exp_row(lf));
        chk("fresh_col", col_out, exp_col(lf));
        tick;
        chk("fresh_fire", fire_out, 1);
        chk("fresh_count", moves_issued, 1);

        // Asynchronous reset in the middle of FIRE
        #2 reset = 1'b0;
        #1;
        chk("arst_fire", fire_out, 0);
        chk("arst_row", row_out, 0);
        chk("arst_col", col_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_moves", moves_issued, 0);
        @(negedge clk);
        start = 1'b1;
        #1 reset = 1'b1;
        tick; start = 1'b0;
        // ACE1: b0=1 -> column, b[2:1]=0 -> col 0001, b3=0
        chk("seed_busy", busy, 1);
        chk("seed_row", row_out, 4'b0000);
        chk("seed_col", col_out, 4'b0001);
        chk("seed_addn", add_n_out, 0);
        abort = 1'b1; tick; abort = 1'b0;

        // NUM_MOVES = 0 instance
        bad0 = 0;
        start0 = 1'b1; tick; start0 = 1'b0;
        chk("zero_done", done0, 1);
        chk("zero_moves", moves0, 0);
        chk("zero_row", row0, 0);
        tick;
        chk("zero_done_once", done0, 0);
        tick;
        chk("zero_never_busy", 16'(bad0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
